neo_multichan_engine: RTL and testbench
=======================================

// Module: neo_multichan_engine
// PURPOSE
//  Parametrised next-generation NEO engine: psi[n] = x[n]^2 - x[n-1]*x[n+1] over C channels of M samples
//  held in a channel-major sample RAM, with a start/done handshake. Results go to a result RAM.
//  Adds full-precision arithmetic, optional output saturation and threshold spike detection/counting.
//  Sits between the sample buffer (1-cycle read latency) and the result buffer / spike logic.
// PARAMETERS
//  N       8   sample width, signed
//  M       16  samples per channel, >= 3
//  C       2   channel count, >= 1
//  OUT_W   17  result width; 2N+1 = exact, < 2N+1 = saturate to signed OUT_W range
//  ADDR_W  $clog2(C*M)  RAM address width (derived, not overridden)
// PORTS
//  Clk          in   1          clock, rising edge
//  reset        in   1          asynchronous, active-low reset
//  start        in   1          begin a run; sampled only in IDLE
//  threshold    in   2N+1       signed spike threshold; sampled at start
//  busy         out  1          high from cycle after accepted start until done pulse inclusive
//  done         out  1          one-cycle pulse after final write
//  ren          out  1          sample RAM read enable
//  raddr        out  ADDR_W     sample address = c*M + n
//  rdata        in   N          signed sample, valid the cycle after ren
//  wen          out  1          result RAM write enable
//  waddr        out  ADDR_W     result address = c*M + n
//  wdata        out  OUT_W      signed psi[n]
//  spike        out  1          high in the cycle wen is high when full-precision psi > threshold
//  spike_count  out  16         spikes in last/current run, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, window registers 0. Reset mid-run aborts; no further writes.
//  - FSM: IDLE -start-> READ -last read issued-> DRAIN -last write-> DONE -1 cycle-> IDLE.
//  - READ: ren=1 every cycle, raddr 0..C*M-1 ascending, no bubbles, incl. channel boundaries.
//  - Each read carries an (index n, channel c) tag through the pipe.
//    On arrival of x[k], shift into a 3-sample window (prev, curr, next).
//  - Write rule: for k >= 2 compute psi[k-1]; write to waddr = c*M + k-1.
//    Indices 0 and M-1 of each channel are never written. No cross-channel mixing.
//  - Latency: read of x[k] issued cycle t -> rdata at t+1 -> wen/waddr/wdata/spike registered at t+2.
//  - Write count: exactly C*(M-2) writes. Run length C*M + 3 cycles from start to done inclusive.
//  - Arithmetic:
//    * products 2N-bit signed, difference in 2N+1 bits; never overflows.
//    * if OUT_W < 2N+1, clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    * spike compares the unsaturated value.
//  - spike_count clears on accepted start, increments per spike, holds after done until next start.
//  - start while busy is ignored. start held high in DONE/IDLE starts a new run the following cycle.
//  - threshold changes mid-run have no effect.
// STRUCTURE
//  - neo_pkg: state_t enum {IDLE, READ, DRAIN, DONE}; function sat_to(width) signed clamp;
//    localparam PSI_W = 2N+1.
//  - Sub-module neo_pipe: 3-tap window, tag pipe, multiply/subtract, saturate, threshold compare.
//  - Top: FSM, read address counter, spike counter.
// TESTING (N=8, M=16, C=2 unless noted)
//  - Constant x=5 in all samples -> 28 writes, all wdata=0, spike never, spike_count=0, done at cycle 35.
//  - Ramp x[n]=n per channel -> every psi=1; with threshold=0, spike on all 28 writes, count=28.
//  - Channel edge: ch0 all 100, ch1 all -3 -> no write uses mixed data;
//    waddr 15,16 never written; ch1 psi=0.
//  - Saturation, OUT_W=8: x[0..2]=127,-128,-128 -> psi[1]=32640, wdata=127,
//    spike with threshold=1000.
//    x[0..2]=-128,127,-128 -> psi[1]=-255, wdata=-128.
//  - Reset asserted mid-READ (cycle 10) -> outputs 0 immediately, no wen afterwards, FSM IDLE.
//    Restart then yields a full 28-write run.
//  - start pulsed during busy -> ignored.
//    C=1, M=3 -> exactly one write at waddr=1, done at cycle 6.

Source files
------------

// File: rtl/neo_pkg.sv
// Shared types and arithmetic helpers for the NEO multichannel engine.
package neo_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned PSI_W = 2 * N_DEF + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  // Clamp a signed value into the signed range of the given width.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int unsigned       width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/neo_pipe.sv
// Sample window, read tag pipe and psi datapath: multiply/subtract, saturate, threshold compare.
module neo_pipe
  import neo_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned M      = 16,
  parameter int unsigned OUT_W  = 17,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NW     = 4
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     vld,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NW-1:0]            idx,
  input  logic signed [N-1:0]      rdata,
  input  logic signed [2*N:0]      threshold,
  output logic                     wen,
  output logic [ADDR_W-1:0]        waddr,
  output logic signed [OUT_W-1:0]  wdata,
  output logic                     spike
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned DW = 2 * N + 1;

  logic                  tag_vld;
  logic [ADDR_W-1:0]     tag_addr;
  logic [NW-1:0]         tag_idx;
  logic signed [N-1:0]   prev;
  logic signed [N-1:0]   curr;
  logic signed [PW-1:0]  sq;
  logic signed [PW-1:0]  cr;
  logic signed [DW-1:0]  psi;
  logic                  fire;

  // prev = x[k-2], curr = x[k-1], rdata = x[k] when the tag for x[k] is valid
  always_comb begin
    sq   = PW'(curr) * PW'(curr);
    cr   = PW'(prev) * PW'(rdata);
    psi  = DW'(sq) - DW'(cr);
    fire = tag_vld && (tag_idx >= NW'(2));
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      tag_vld  <= 1'b0;
      tag_addr <= '0;
      tag_idx  <= '0;
      prev     <= '0;
      curr     <= '0;
      wen      <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      spike    <= 1'b0;
    end else begin
      tag_vld  <= vld;
      tag_addr <= addr;
      tag_idx  <= idx;
      if (tag_vld) begin
        prev <= curr;
        curr <= rdata;
      end
      wen   <= fire;
      spike <= fire && (psi > threshold);
      if (fire) begin
        waddr <= tag_addr - ADDR_W'(1);
        wdata <= OUT_W'(sat_to(64'(psi), OUT_W));
      end
    end
  end

endmodule

// File: rtl/neo_multichan_engine.sv
// NEO engine top: run FSM, channel-major read sequencer and spike counter around neo_pipe.
module neo_multichan_engine
  import neo_pkg::*;
#(
  parameter  int unsigned N      = 8,
  parameter  int unsigned M      = 16,
  parameter  int unsigned C      = 2,
  parameter  int unsigned OUT_W  = 17,
  localparam int unsigned ADDR_W = $clog2(C * M)
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [2*N:0]      threshold,
  output logic                     busy,
  output logic                     done,
  output logic                     ren,
  output logic [ADDR_W-1:0]        raddr,
  input  logic signed [N-1:0]      rdata,
  output logic                     wen,
  output logic [ADDR_W-1:0]        waddr,
  output logic signed [OUT_W-1:0]  wdata,
  output logic                     spike,
  output logic [15:0]              spike_count
);

  localparam int unsigned NW = $clog2(M);
  localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(C * M - 1);
  localparam logic [ADDR_W-1:0] LAST_W = ADDR_W'(C * M - 2);

  state_t              state;
  state_t              state_n;
  logic                ren_n;
  logic [ADDR_W-1:0]   raddr_n;
  logic [NW-1:0]       idx;
  logic [NW-1:0]       idx_n;
  logic                start_acc;
  logic signed [2*N:0] thr_q;

  // Next-state and next read-sequencer values
  always_comb begin
    state_n   = state;
    ren_n     = 1'b0;
    raddr_n   = raddr;
    idx_n     = idx;
    start_acc = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = READ;
          ren_n     = 1'b1;
          raddr_n   = '0;
          idx_n     = '0;
          start_acc = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      READ: begin
        if (raddr == LAST_R) begin
          state_n = DRAIN;
        end else begin
          ren_n   = 1'b1;
          raddr_n = raddr + ADDR_W'(1);
          idx_n   = (idx == NW'(M - 1)) ? '0 : idx + NW'(1);
        end
      end
      DRAIN: begin
        if (wen && (waddr == LAST_W)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ren         <= 1'b0;
      raddr       <= '0;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      thr_q       <= '0;
      spike_count <= '0;
    end else begin
      state <= state_n;
      ren   <= ren_n;
      raddr <= raddr_n;
      idx   <= idx_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      if (start_acc) begin
        thr_q       <= threshold;
        spike_count <= '0;
      end else if (spike && (spike_count != 16'hFFFF)) begin
        spike_count <= spike_count + 16'd1;
      end
    end
  end

  neo_pipe #(
    .N      (N),
    .M      (M),
    .OUT_W  (OUT_W),
    .ADDR_W (ADDR_W),
    .NW     (NW)
  ) u_pipe (
    .Clk       (Clk),
    .reset     (reset),
    .vld       (ren),
    .addr      (raddr),
    .idx       (idx),
    .rdata     (rdata),
    .threshold (thr_q),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .spike     (spike)
  );

endmodule

// File: tb/tb_neo_multichan_engine.sv
// Directed bench: a C=2/M=16 exact engine and a C=1/M=3 saturating (OUT_W=8) engine.
module tb_neo_multichan_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic               start_m, busy_m, done_m, ren_m, wen_m, spike_m;
  logic signed [16:0] thr_m, wdata_m;
  logic [4:0]         raddr_m, waddr_m;
  logic signed [7:0]  rdata_m;
  logic [15:0]        cnt_m;

  logic               start_s, busy_s, done_s, ren_s, wen_s, spike_s;
  logic signed [16:0] thr_s;
  logic signed [7:0]  wdata_s, rdata_s;
  logic [1:0]         raddr_s, waddr_s;
  logic [15:0]        cnt_s;

  neo_multichan_engine u_main (
    .Clk(clk), .reset(rst_n), .start(start_m), .threshold(thr_m),
    .busy(busy_m), .done(done_m), .ren(ren_m), .raddr(raddr_m), .rdata(rdata_m),
    .wen(wen_m), .waddr(waddr_m), .wdata(wdata_m), .spike(spike_m), .spike_count(cnt_m)
  );

  neo_multichan_engine #(.N(8), .M(3), .C(1), .OUT_W(8)) u_small (
    .Clk(clk), .reset(rst_n), .start(start_s), .threshold(thr_s),
    .busy(busy_s), .done(done_s), .ren(ren_s), .raddr(raddr_s), .rdata(rdata_s),
    .wen(wen_s), .waddr(waddr_s), .wdata(wdata_s), .spike(spike_s), .spike_count(cnt_s)
  );

  // Sample RAMs with one-cycle read latency
  logic signed [7:0] mem_m [32];
  logic signed [7:0] mem_s [4];
  always @(posedge clk) if (ren_m) rdata_m <= mem_m[raddr_m];
  always @(posedge clk) if (ren_s) rdata_s <= mem_s[raddr_s];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result RAM observers
  int                 wr_m, spk_m, wr_s, spk_s;
  logic signed [16:0] res_m [32];
  bit                 wm_m [32];
  logic [1:0]         la_s;
  logic signed [7:0]  ld_s;

  always @(negedge clk) begin
    if (wen_m) begin
      wr_m++;
      if (spike_m) spk_m++;
      res_m[waddr_m] = wdata_m;
      wm_m[waddr_m]  = 1'b1;
    end
    if (wen_s) begin
      wr_s++;
      if (spike_s) spk_s++;
      la_s = waddr_s;
      ld_s = wdata_s;
    end
  end

  task automatic clear_mon();
    wr_m = 0; spk_m = 0; wr_s = 0; spk_s = 0; la_s = '0; ld_s = '0;
    for (int a = 0; a < 32; a++) begin
      res_m[a] = '0;
      wm_m[a]  = 1'b0;
    end
  endtask

  task automatic run(input bit sel, input int pulse_at, input int thr_at,
                     input logic signed [16:0] thr_new,
                     output int dcyc, output bit b1, output bit bd);
    dcyc = -1; b1 = 1'b0; bd = 1'b0;
    clear_mon();
    @(negedge clk);
    if (sel) start_s = 1'b1; else start_m = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_m = 1'b0; start_s = 1'b0;
        b1 = sel ? busy_s : busy_m;
      end
      if (c == pulse_at) start_m = 1'b1;
      if (c == pulse_at + 1) start_m = 1'b0;
      if (c == thr_at) thr_m = thr_new;
      if ((sel ? done_s : done_m) == 1'b1) begin
        dcyc = c;
        bd   = sel ? busy_s : busy_m;
        break;
      end
    end
  endtask

  // Interior indices 1..M-2 of each channel written with exp_val, nothing else
  task automatic check_main(input string tag, input longint exp_val);
    int bad;
    bit want;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      want = (a % 16 != 0) && (a % 16 != 15);
      if (wm_m[a] != want || (want && res_m[a] != exp_val)) bad++;
    end
    chk(tag, bad, 0);
  endtask

  int dc;
  bit b1, bd;

  initial begin
    rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; thr_m = '0; thr_s = '0;
    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_ren", ren_m, 0);
    chk("rst_wen", wen_m, 0);
    chk("rst_wdata", wdata_m, 0);
    chk("rst_count", cnt_m, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant 5: psi = 0 everywhere; start pulse mid-run ignored
    for (int a = 0; a < 32; a++) mem_m[a] = 8'sd5;
    thr_m = 17'sd0;
    run(1'b0, 10, 0, 17'sd0, dc, b1, bd);
    chk("const_done_cyc", dc, 35);
    chk("const_busy_c1", b1, 1);
    chk("const_busy_done", bd, 1);
    chk("const_writes", wr_m, 28);
    chk("const_spikes", spk_m, 0);
    chk("const_count", cnt_m, 0);
    check_main("const_data", 0);
    @(negedge clk);
    chk("const_done_pulse", done_m, 0);
    chk("const_busy_after", busy_m, 0);

    // Ramp: psi = 1; threshold raised mid-run must not matter
    for (int a = 0; a < 32; a++) mem_m[a] = 8'(a % 16);
    thr_m = 17'sd0;
    run(1'b0, 0, 5, 17'sd100, dc, b1, bd);
    chk("ramp_done_cyc", dc, 35);
    chk("ramp_writes", wr_m, 28);
    chk("ramp_spikes", spk_m, 28);
    chk("ramp_count", cnt_m, 28);
    check_main("ramp_data", 1);
    repeat (3) @(negedge clk);
    chk("ramp_count_hold", cnt_m, 28);

    // Channel boundary: ch0 = 100, ch1 = -3
    for (int a = 0; a < 32; a++) mem_m[a] = (a < 16) ? 8'sd100 : -8'sd3;
    thr_m = 17'sd0;
    run(1'b0, 0, 0, 17'sd0, dc, b1, bd);
    chk("edge_writes", wr_m, 28);
    chk("edge_w15", wm_m[15], 0);
    chk("edge_w16", wm_m[16], 0);
    check_main("edge_data", 0);
    chk("edge_spikes", spk_m, 0);

    // Reset asserted mid-READ
    for (int a = 0; a < 32; a++) mem_m[a] = 8'(a % 16);
    thr_m = 17'sd0;
    clear_mon();
    @(negedge clk);
    start_m = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_m = 1'b0;
    end
    chk("abort_pre_ren", ren_m, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ren", ren_m, 0);
    chk("abort_busy", busy_m, 0);
    chk("abort_wen", wen_m, 0);
    chk("abort_raddr", raddr_m, 0);
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_writes", wr_m, 0);
    chk("abort_idle", busy_m, 0);
    run(1'b0, 0, 0, 17'sd0, dc, b1, bd);
    chk("restart_done_cyc", dc, 35);
    chk("restart_writes", wr_m, 28);
    chk("restart_count", cnt_m, 28);

    // Saturation, positive: psi[1] = 32640 -> 127, spike over 1000
    mem_s[0] = 8'sd127; mem_s[1] = -8'sd128; mem_s[2] = -8'sd128; mem_s[3] = 8'sd0;
    thr_s = 17'sd1000;
    run(1'b1, 0, 0, 17'sd0, dc, b1, bd);
    chk("satp_done_cyc", dc, 6);
    chk("satp_writes", wr_s, 1);
    chk("satp_waddr", la_s, 1);
    chk("satp_wdata", ld_s, 127);
    chk("satp_spikes", spk_s, 1);
    chk("satp_count", cnt_s, 1);

    // Saturation, negative: psi[1] = -255 -> -128
    mem_s[0] = -8'sd128; mem_s[1] = 8'sd127; mem_s[2] = -8'sd128;
    thr_s = 17'sd0;
    run(1'b1, 0, 0, 17'sd0, dc, b1, bd);
    chk("satn_done_cyc", dc, 6);
    chk("satn_writes", wr_s, 1);
    chk("satn_wdata", ld_s, -128);
    chk("satn_count", cnt_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
